// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_arb_pkg : shared encodings for the data-memory arbiter     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package dmem_arb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Word-misaligned or beyond the last implemented word.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_arb2 : two-way round-robin pick with priority pointer        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Remembers the most recent winner; starting at DMA gives CPU first priority.
  owner_t     r_last;
  logic [1:0] w_pick;

  always_comb begin
    w_pick = req;
    if (req == 2'b11) begin
      w_pick = (r_last == OWN_DMA) ? 2'b01 : 2'b10;
    end
    gnt = accept ? w_pick : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= OWN_DMA;
    end else if (gnt != 2'b00) begin
      r_last <= gnt[1] ? OWN_DMA : OWN_CPU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_arbiter : CPU/DMA round-robin access to one data memory    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_t      r_state, w_state_nxt;
  owner_t      r_owner;
  logic        r_we, r_fault;
  logic [31:0] r_addr, r_wdata;
  logic        r_cpu_rvalid, r_cpu_err, r_dma_rvalid, r_dma_err;
  logic [31:0] r_cpu_rdata, r_dma_rdata;

  logic        w_accept, w_in_access;
  logic [1:0]  w_gnt;
  logic        w_sel_we;
  logic [31:0] w_sel_addr, w_sel_wdata, w_resp_data;

  // Gating with reset_n keeps gnt low while reset is held.
  assign w_accept = (r_state == IDLE) && reset_n;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({dma_req, cpu_req}),
    .accept  (w_accept),
    .gnt     (w_gnt)
  );

  assign cpu_gnt     = w_gnt[0];
  assign dma_gnt     = w_gnt[1];
  assign w_sel_we    = w_gnt[1] ? dma_we    : cpu_we;
  assign w_sel_addr  = w_gnt[1] ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_gnt[1] ? dma_wdata : cpu_wdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt != 2'b00) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt != 2'b00) begin
      r_owner <= w_gnt[1] ? OWN_DMA : OWN_CPU;
      r_we    <= w_sel_we;
      r_fault <= addr_fault(w_sel_addr, DEPTH);
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  assign w_in_access = (r_state == ACCESS);
  assign mem_we      = w_in_access && r_we && !r_fault;
  assign mem_a       = w_in_access ? r_addr  : '0;
  assign mem_wd      = w_in_access ? r_wdata : '0;

  // Writes and faulted reads return zero data.
  assign w_resp_data = (!r_we && !r_fault) ? mem_rd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_err    <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
      r_dma_err    <= 1'b0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_err    <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
      r_dma_err    <= 1'b0;
      if (w_in_access) begin
        if (r_owner == OWN_CPU) begin
          r_cpu_rvalid <= 1'b1;
          r_cpu_rdata  <= w_resp_data;
          r_cpu_err    <= r_fault;
        end else begin
          r_dma_rvalid <= 1'b1;
          r_dma_rdata  <= w_resp_data;
          r_dma_err    <= r_fault;
        end
      end
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_err    = r_cpu_err;
  assign dma_rvalid = r_dma_rvalid;
  assign dma_rdata  = r_dma_rdata;
  assign dma_err    = r_dma_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_dmem_arbiter : directed vector bench for dmem_arbiter        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_load;
  logic [31:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_err    (dma_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Memory model: word i preloads to A000_0000+i; out-of-range reads return a poison value.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_we && (mem_a[31:2] < 30'(DEPTH))) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  always_comb begin
    if (mem_a[31:2] < 30'(DEPTH)) mem_rd = mem[mem_a[7:2]];
    else                          mem_rd = 32'hBAD0_BAD0;
  end

  typedef struct packed {
    logic        cg, crv;
    logic [31:0] crd;
    logic        cerr, dg, drv;
    logic [31:0] drd;
    logic        derr, mwe;
    logic [31:0] ma, mwd;
  } out_t;

  typedef struct {
    string       name;
    bit          rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t o(logic cg, logic crv, logic [31:0] crd, logic cerr,
                             logic dg, logic drv, logic [31:0] drd, logic derr,
                             logic mwe, logic [31:0] ma, logic [31:0] mwd);
    return out_t'({cg, crv, crd, cerr, dg, drv, drd, derr, mwe, ma, mwd});
  endfunction

  task automatic add(string name, bit rst,
                     logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                     logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd, out_t exp);
    vec_t v;
    v.name = name; v.rst = rst;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                       logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
  endtask

  task automatic check_out(string name, out_t exp);
    out_t act;
    act = o(cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, dma_gnt, dma_rvalid, dma_rdata,
            dma_err, mem_we, mem_a, mem_wd);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cg=%b crv=%b crd=%h cerr=%b dg=%b drv=%b drd=%h derr=%b we=%b a=%h wd=%h; want cg=%b crv=%b crd=%h cerr=%b dg=%b drv=%b drd=%h derr=%b we=%b a=%h wd=%h",
               name, act.cg, act.crv, act.crd, act.cerr, act.dg, act.drv, act.drd, act.derr,
               act.mwe, act.ma, act.mwd, exp.cg, exp.crv, exp.crd, exp.cerr, exp.dg, exp.drv,
               exp.drd, exp.derr, exp.mwe, exp.ma, exp.mwd);
    end
  endtask

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    mem_load = 1'b1;
    drive(1, 1, 32'h10, 32'h1111_1111, 1, 0, 32'h20, 0);

    // Requests while reset is held must not produce a grant.
    @(negedge clk); #1;
    check_out("reset_state", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    mem_load = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n  = 1'b1;

    // CPU write then read-back of word 0x10.
    add("A0_cpu_wr_gnt", 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("A1_wr_access",  0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'hDEADBEEF));
    add("A2_wr_rv_rdgnt",0, 1, 0, 32'h10, 0, 0, 0, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("A3_rd_access",  0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0));
    add("A4_rd_rvalid",  0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0));
    // Both requesting from reset: CPU, DMA, CPU.
    add("B0_both_cpu",   1, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("B1_access_cpu", 0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0));
    add("B2_both_dma",   0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, o(0, 1, 32'hA000_0001, 0, 1, 0, 0, 0, 0, 0, 0));
    add("B3_access_dma", 0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0));
    add("B4_both_cpu2",  0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, o(1, 0, 0, 0, 0, 1, 32'hA000_0002, 0, 0, 0, 0));
    add("B5_access_cpu2",0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0));
    add("B6_cpu_rvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 1, 32'hA000_0001, 0, 0, 0, 0, 0, 0, 0, 0));
    // Misaligned DMA write, then out-of-range CPU read.
    add("C0_dma_mis_gnt",0, 0, 0, 0, 0, 1, 1, 32'h102, 32'h1234_5678, o(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add("C1_mis_no_we",  0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h102, 32'h1234_5678));
    add("C2_dma_err",    0, 1, 0, 32'h100, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    add("C3_oor_access", 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0));
    add("C4_cpu_err",    0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // DMA alone, four back-to-back reads.
    add("D0_dma_gnt1",   0, 0, 0, 0, 0, 1, 0, 32'hC,  0, o(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add("D1_access1",    0, 0, 0, 0, 0, 1, 0, 32'h14, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0));
    add("D2_rv1_gnt2",   0, 0, 0, 0, 0, 1, 0, 32'h14, 0, o(0, 0, 0, 0, 1, 1, 32'hA000_0003, 0, 0, 0, 0));
    add("D3_access2",    0, 0, 0, 0, 0, 1, 0, 32'h18, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h14, 0));
    add("D4_rv2_gnt3",   0, 0, 0, 0, 0, 1, 0, 32'h18, 0, o(0, 0, 0, 0, 1, 1, 32'hA000_0005, 0, 0, 0, 0));
    add("D5_access3",    0, 0, 0, 0, 0, 1, 0, 32'h1C, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h18, 0));
    add("D6_rv3_gnt4",   0, 0, 0, 0, 0, 1, 0, 32'h1C, 0, o(0, 0, 0, 0, 1, 1, 32'hA000_0006, 0, 0, 0, 0));
    add("D7_access4",    0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1C, 0));
    add("D8_rv4",        0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 32'hA000_0007, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      if (vecs[k].rst) pulse_reset();
      @(negedge clk);
      drive(vecs[k].creq, vecs[k].cwe, vecs[k].caddr, vecs[k].cwd,
            vecs[k].dreq, vecs[k].dwe, vecs[k].daddr, vecs[k].dwd);
      #1;
      check_out(vecs[k].name, vecs[k].exp);
    end

    // Reset in the middle of a CPU write to word 8.
    @(negedge clk);
    drive(1, 1, 32'h20, 32'h55AA_55AA, 0, 0, 0, 0);
    #1;
    check1("E_gnt", 32'(cpu_gnt), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check1("E_access_we", 32'(mem_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("E_reset_mid_access", o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check1("E_no_rvalid", 32'(cpu_rvalid), 32'd0);
    end
    check1("E_mem_unchanged", mem[8], 32'hA000_0008);

    // The interrupted requester re-requests and completes.
    @(negedge clk);
    drive(1, 1, 32'h20, 32'h55AA_55AA, 0, 0, 0, 0);
    #1;
    check1("E_regnt", 32'(cpu_gnt), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check_out("E_retry_rvalid", o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check1("E_mem_written", mem[8], 32'h55AA_55AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
